// File: rtl/store_uart_pkg.sv
// store_uart_pkg: FSM state type and default addresses for store_uart_tx.
// STORE_UART_TX_PARITY_EN adds the PARITY state.
package store_uart_pkg;
   localparam logic [31:0] TX_ADDR_DEF = 32'h0000_FFF8;
   localparam logic [31:0] CTRL_ADDR_DEF = 32'h0000_FFFC;
   localparam int DATA_BITS = 8;
`ifdef STORE_UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
`endif
endpackage

// File: rtl/store_uart_tx_fifo.sv
// tx_byte_fifo: synchronous byte FIFO with count; pointers wrap naturally (power-of-two depth).
module tx_byte_fifo #(
   parameter int DEPTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          push,
   input  logic          pop,
   input  logic [7:0]    wdata,
   output logic [7:0]    rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);
   logic [7:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic wr, rd;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign wr = push && !full;
   assign rd = pop && !empty;
   assign rdata = mem[rptr];
   always_ff @(posedge clk)
      if (wr) mem[wptr] <= wdata;
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         count <= '0;
      end else begin
         wptr <= wptr + AW'(wr);
         rptr <= rptr + AW'(rd);
         count <= count + CW'(wr) - CW'(rd);
      end
   end
endmodule

// File: rtl/store_uart_tx.sv
// store_uart_tx: store-mapped UART transmitter (8N1, LSB first) fed by a byte FIFO.
// Define STORE_UART_TX_PARITY_EN to add an even-parity bit before STOP.
module store_uart_tx
   import store_uart_pkg::*;
#(
   parameter logic [31:0] TX_ADDR = TX_ADDR_DEF,
   parameter logic [31:0] CTRL_ADDR = CTRL_ADDR_DEF,
   parameter int CLKS_PER_BIT = 16,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memwrite,
   input  logic [31:0] aluresult,
   input  logic [31:0] writedata,
   output logic        tx,
   output logic        busy,
   output logic        fifo_full,
   output logic        overflow
);
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);
   uart_state_t state;
   logic [BW-1:0] baud;
   logic [2:0] bit_cnt;
   logic [7:0] shift, head;
   logic [CW-1:0] count;
   logic empty, tx_hit, push, pop, clr, last, unused;
`ifdef STORE_UART_TX_PARITY_EN
   logic par;
`endif
   assign tx_hit = memwrite && aluresult == TX_ADDR;
   assign clr = memwrite && aluresult == CTRL_ADDR && writedata[0];
   assign push = tx_hit && !fifo_full;
   assign pop = state == IDLE && !empty;
   assign last = baud == BAUD_LAST;
   assign busy = state != IDLE || count != '0;
   assign unused = ^writedata[31:8];
   tx_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk), .reset(reset), .push(push), .pop(pop), .wdata(writedata[7:0]),
      .rdata(head), .full(fifo_full), .empty(empty), .count(count)
   );
   // a dropped store sets the flag even if a clear arrives the same cycle
   always_ff @(posedge clk) begin
      if (reset) overflow <= 1'b0;
      else if (tx_hit && fifo_full) overflow <= 1'b1;
      else if (clr) overflow <= 1'b0;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         baud <= '0;
         bit_cnt <= '0;
         shift <= '0;
         tx <= 1'b1;
      end else begin
         baud <= (state == IDLE || last) ? '0 : baud + BW'(1);
         case (state)
            IDLE: if (pop) begin
               state <= START;
               shift <= head;
               tx <= 1'b0;
`ifdef STORE_UART_TX_PARITY_EN
               par <= ^head;
`endif
            end
            START: if (last) begin
               state <= DATA;
               tx <= shift[0];
               bit_cnt <= '0;
            end
            DATA: if (last) begin
               if (bit_cnt == BIT_LAST) begin
`ifdef STORE_UART_TX_PARITY_EN
                  state <= PARITY;
                  tx <= par;
`else
                  state <= STOP;
                  tx <= 1'b1;
`endif
               end else begin
                  shift <= shift >> 1;
                  tx <= shift[1];
                  bit_cnt <= bit_cnt + 3'd1;
               end
            end
`ifdef STORE_UART_TX_PARITY_EN
            PARITY: if (last) begin
               state <= STOP;
               tx <= 1'b1;
            end
`endif
            STOP: if (last) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
